// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundles the signals between the five-stage pipeline and the hazard /
//   interrupt-entry controller.
//
//   master modport : pipeline side. It drives the hazard inputs and receives
//                    the stall/flush/vector controls.
//   slave modport  : hazard_ctrl side.
//
//   Pipeline -> controller
//     id_regsrc1_i, id_regsrc2_i  [3:0]  ID source registers
//     id_rd1_en_i, id_rd2_en_i           ID actually reads src1/src2
//     ex_memread_i                       EX holds a load
//     ex_regdst_i                 [3:0]  EX destination register
//     id_branch_taken_i                  branch/jump in ID resolved taken
//     mem_if_conflict_i                  MEM uses instruction RAM this cycle
//     int_req_i                          level interrupt request
//     id_epc_i                    [15:0] PC of the instruction in ID
//   Controller -> pipeline
//     pc_stall_o, if_id_stall_o, flush_if_o, flush_id_o,
//     pc_vector_o, int_ack_o, epc_o[15:0], stall_cnt_o[15:0]
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
    logic [3:0]  id_regsrc1_i;
    logic [3:0]  id_regsrc2_i;
    logic        id_rd1_en_i;
    logic        id_rd2_en_i;
    logic        ex_memread_i;
    logic [3:0]  ex_regdst_i;
    logic        id_branch_taken_i;
    logic        mem_if_conflict_i;
    logic        int_req_i;
    logic [15:0] id_epc_i;

    logic        pc_stall_o;
    logic        if_id_stall_o;
    logic        flush_if_o;
    logic        flush_id_o;
    logic        pc_vector_o;
    logic        int_ack_o;
    logic [15:0] epc_o;
    logic [15:0] stall_cnt_o;

    modport master (
        output id_regsrc1_i, id_regsrc2_i, id_rd1_en_i, id_rd2_en_i,
               ex_memread_i, ex_regdst_i, id_branch_taken_i,
               mem_if_conflict_i, int_req_i, id_epc_i,
        input  pc_stall_o, if_id_stall_o, flush_if_o, flush_id_o,
               pc_vector_o, int_ack_o, epc_o, stall_cnt_o
    );

    modport slave (
        input  id_regsrc1_i, id_regsrc2_i, id_rd1_en_i, id_rd2_en_i,
               ex_memread_i, ex_regdst_i, id_branch_taken_i,
               mem_if_conflict_i, int_req_i, id_epc_i,
        output pc_stall_o, if_id_stall_o, flush_if_o, flush_id_o,
               pc_vector_o, int_ack_o, epc_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard and interrupt-entry controller for the 16-bit five-stage
//   core. It produces the stall/flush controls for PC, IF/ID and ID/EX,
//   detects load-use and instruction-RAM structural hazards, squashes the
//   wrong-path fetch after a taken branch, and sequences interrupt entry:
//   accept (EPC captured) -> DRAIN bubbles -> one VECTOR cycle.
//
// Ports
//   CLK   rising-edge clock
//   RST   synchronous active-high reset
//   hif   hazard_ctrl_if.slave (all pipeline-facing signals)
//
// Parameters
//   NO_REG        regdst encoding meaning "no register write"
//   DRAIN_CYCLES  bubble cycles before vectoring, accept cycle included (1..15)
//
// Optional feature
//   HAZARD_PERF_CNT_EN : when defined, stall_cnt_o is a saturating count of
//   PC-stall cycles. When undefined, stall_cnt_o is tied to zero and no
//   counter is built.
//
// Control outputs are combinational from the state and the inputs. Only the
// state, the drain counter, the EPC and the stall counter are registered.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter logic [3:0] NO_REG       = 4'hF,
    parameter int         DRAIN_CYCLES = 3
) (
    input  logic          CLK,
    input  logic          RST,
    hazard_ctrl_if.slave  hif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        VECTOR = 2'd2
    } state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [15:0] epc_reg;

    logic load_use;
    logic int_accept;
    logic pc_stall;
    logic if_id_stall;
    logic flush_if;
    logic flush_id;
    logic pc_vector;
    logic int_ack;

    // A load in EX that writes a register the ID instruction actually reads.
    assign load_use = hif.ex_memread_i && (hif.ex_regdst_i != NO_REG) &&
                      ((hif.id_rd1_en_i && (hif.id_regsrc1_i == hif.ex_regdst_i)) ||
                       (hif.id_rd2_en_i && (hif.id_regsrc2_i == hif.ex_regdst_i)));

    // An interrupt is only taken on a clean boundary. A load-use stall or a
    // taken branch would otherwise corrupt the EPC.
    assign int_accept = (state_reg == RUN) && hif.int_req_i &&
                        !load_use && !hif.id_branch_taken_i;

    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        pc_vector   = 1'b0;
        int_ack     = 1'b0;
        case (state_reg)
            RUN: begin
                if (int_accept || load_use) begin
                    // Freeze the front end and let a bubble enter EX.
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    flush_id    = 1'b1;
                end else if (hif.id_branch_taken_i) begin
                    // The wrong-path fetch is squashed. A RAM conflict in the
                    // same cycle does not matter because that fetch is discarded.
                    flush_if = 1'b1;
                end else if (hif.mem_if_conflict_i) begin
                    // No fetch this cycle. Refetch the same PC and let ID
                    // advance into a bubble.
                    pc_stall = 1'b1;
                    flush_if = 1'b1;
                end
            end
            DRAIN: begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                flush_id    = 1'b1;
            end
            VECTOR: begin
                pc_vector = 1'b1;
                flush_if  = 1'b1;
                int_ack   = 1'b1;
            end
            default: begin
            end
        endcase
        if (RST) begin
            pc_stall    = 1'b0;
            if_id_stall = 1'b0;
            flush_if    = 1'b0;
            flush_id    = 1'b0;
            pc_vector   = 1'b0;
            int_ack     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= RUN;
            cnt_reg   <= 4'd0;
            epc_reg   <= 16'h0000;
        end else begin
            case (state_reg)
                RUN: begin
                    if (int_accept) begin
                        epc_reg <= hif.id_epc_i;
                        if (DRAIN_CYCLES == 1) begin
                            state_reg <= VECTOR;
                        end else begin
                            // The accept cycle is the first bubble, so the
                            // DRAIN state covers DRAIN_CYCLES-1 cycles.
                            state_reg <= DRAIN;
                            cnt_reg   <= 4'(DRAIN_CYCLES - 2);
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= VECTOR;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                VECTOR: begin
                    state_reg <= RUN;
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_reg;

    // pc_stall is already forced low during reset. The reset branch takes
    // priority anyway.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_reg <= 16'h0000;
        end else if (pc_stall && (state_reg != VECTOR) && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign hif.stall_cnt_o = stall_cnt_reg;
`else
    assign hif.stall_cnt_o = 16'h0000;
`endif

    assign hif.pc_stall_o    = pc_stall;
    assign hif.if_id_stall_o = if_id_stall;
    assign hif.flush_if_o    = flush_if;
    assign hif.flush_id_o    = flush_id;
    assign hif.pc_vector_o   = pc_vector;
    assign hif.int_ack_o     = int_ack;
    assign hif.epc_o         = epc_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed-vector bench for hazard_ctrl (default parameters, DRAIN_CYCLES=3).
//   The driver applies one input vector per cycle, #1 after the rising edge,
//   and pushes the hand-computed expected outputs into a scoreboard queue. A
//   monitor pops one entry on each falling edge and compares it with the DUT.
//   Output bit order in vectors: {pc_stall, if_id_stall, flush_if, flush_id,
//   pc_vector, int_ack}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [5:0] O_NONE   = 6'b000000;
    localparam logic [5:0] O_BUBBLE = 6'b110100; // pc_stall, if_id_stall, flush_id
    localparam logic [5:0] O_BRANCH = 6'b001000; // flush_if
    localparam logic [5:0] O_CONFL  = 6'b101000; // pc_stall, flush_if
    localparam logic [5:0] O_VECTOR = 6'b001011; // flush_if, pc_vector, int_ack

    typedef struct {
        string       name;
        logic [5:0]  bits;
        logic [15:0] epc;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    hazard_ctrl_if hif();

    hazard_ctrl #(
        .NO_REG       (4'hF),
        .DRAIN_CYCLES (3)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .hif (hif.slave)
    );

    exp_t        sb[$];
    int          n_cmp;
    int          n_bad;
    logic [15:0] model_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rst                   = 1'b0;
        hif.id_regsrc1_i      = 4'd0;
        hif.id_regsrc2_i      = 4'd0;
        hif.id_rd1_en_i       = 1'b0;
        hif.id_rd2_en_i       = 1'b0;
        hif.ex_memread_i      = 1'b0;
        hif.ex_regdst_i       = 4'd0;
        hif.id_branch_taken_i = 1'b0;
        hif.mem_if_conflict_i = 1'b0;
        hif.int_req_i         = 1'b0;
        hif.id_epc_i          = 16'h0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    // The expected stall count is the value registered before this cycle's
    // edge. The model is then advanced for the coming edge.
    task automatic expect_o(input string name, input logic [5:0] b, input logic [15:0] e);
        exp_t t;
        t.name = name;
        t.bits = b;
        t.epc  = e;
        t.cnt  = model_cnt;
        sb.push_back(t);
`ifdef HAZARD_PERF_CNT_EN
        if (rst) model_cnt = 16'h0000;
        else if (b[5] && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
`endif
    endtask

    task automatic load_r3_src2();
        hif.ex_memread_i = 1'b1;
        hif.ex_regdst_i  = 4'd3;
        hif.id_regsrc1_i = 4'd5;
        hif.id_rd1_en_i  = 1'b1;
        hif.id_regsrc2_i = 4'd3;
        hif.id_rd2_en_i  = 1'b1;
    endtask

    // Monitor: one comparison per scoreboard entry, on the falling edge.
    initial begin
        exp_t        t;
        logic [5:0]  got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                t   = sb.pop_front();
                got = {hif.pc_stall_o, hif.if_id_stall_o, hif.flush_if_o,
                       hif.flush_id_o, hif.pc_vector_o, hif.int_ack_o};
                n_cmp++;
                if (got !== t.bits || hif.epc_o !== t.epc || hif.stall_cnt_o !== t.cnt) begin
                    n_bad++;
                    $display("FAIL %s: got ctl=%b epc=%h cnt=%h, required ctl=%b epc=%h cnt=%h",
                             t.name, got, hif.epc_o, hif.stall_cnt_o, t.bits, t.epc, t.cnt);
                end else begin
                    $display("ok   %s: ctl=%b epc=%h cnt=%h", t.name, got, hif.epc_o, hif.stall_cnt_o);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        model_cnt = 16'h0000;
        idle();
        rst = 1'b1;

        // Reset: two unchecked edges, then a checked cycle with hazards present.
        tick(); rst = 1'b1;
        tick(); rst = 1'b1;
        tick(); rst = 1'b1; hif.mem_if_conflict_i = 1'b1; hif.int_req_i = 1'b1; load_r3_src2();
        expect_o("reset_forces_zero", O_NONE, 16'h0000);

        // Load-use hazards
        tick(); load_r3_src2();                       expect_o("load_use_src2", O_BUBBLE, 16'h0000);
        tick();                                       expect_o("after_bubble", O_NONE, 16'h0000);
        tick(); load_r3_src2(); hif.ex_regdst_i = 4'hF; hif.id_regsrc2_i = 4'hF;
                                                      expect_o("regdst_no_reg", O_NONE, 16'h0000);
        tick(); load_r3_src2(); hif.id_rd2_en_i = 1'b0; expect_o("rd2_disabled", O_NONE, 16'h0000);
        tick(); load_r3_src2(); hif.id_regsrc1_i = 4'd3; hif.id_regsrc2_i = 4'd7;
                                                      expect_o("load_use_src1", O_BUBBLE, 16'h0000);
        tick(); load_r3_src2(); hif.ex_memread_i = 1'b0; expect_o("no_load", O_NONE, 16'h0000);
        tick(); load_r3_src2(); hif.mem_if_conflict_i = 1'b1;
                                                      expect_o("load_use_conflict", O_BUBBLE, 16'h0000);

        // Branch and structural hazards
        tick(); hif.id_branch_taken_i = 1'b1; hif.mem_if_conflict_i = 1'b1;
                                                      expect_o("branch_over_conflict", O_BRANCH, 16'h0000);
        tick(); hif.mem_if_conflict_i = 1'b1;         expect_o("conflict_alone", O_CONFL, 16'h0000);
        tick(); hif.id_branch_taken_i = 1'b1;         expect_o("branch_alone", O_BRANCH, 16'h0000);

        // Interrupt entry: accept, 2 DRAIN, VECTOR. DRAIN ignores inputs.
        tick(); hif.int_req_i = 1'b1; hif.id_epc_i = 16'h0124;
                                                      expect_o("int_accept", O_BUBBLE, 16'h0000);
        tick(); hif.int_req_i = 1'b1; hif.id_branch_taken_i = 1'b1;
                                                      expect_o("drain_1", O_BUBBLE, 16'h0124);
        tick(); hif.int_req_i = 1'b1; hif.mem_if_conflict_i = 1'b1;
                                                      expect_o("drain_2", O_BUBBLE, 16'h0124);
        tick(); hif.int_req_i = 1'b1;                 expect_o("vector", O_VECTOR, 16'h0124);
        tick();                                       expect_o("epc_hold", O_NONE, 16'h0124);

        // Interrupt blocked by a taken branch, then by load-use, then accepted.
        tick(); hif.int_req_i = 1'b1; hif.id_branch_taken_i = 1'b1; hif.id_epc_i = 16'h0150;
                                                      expect_o("int_vs_branch", O_BRANCH, 16'h0124);
        tick(); hif.int_req_i = 1'b1; load_r3_src2(); hif.id_epc_i = 16'h0160;
                                                      expect_o("int_vs_load_use", O_BUBBLE, 16'h0124);
        tick(); hif.int_req_i = 1'b1; hif.id_epc_i = 16'h0200;
                                                      expect_o("int_accept_late", O_BUBBLE, 16'h0124);
        tick(); hif.int_req_i = 1'b1;                 expect_o("drain_1b", O_BUBBLE, 16'h0200);
        tick(); hif.int_req_i = 1'b1;                 expect_o("drain_2b", O_BUBBLE, 16'h0200);
        tick(); hif.int_req_i = 1'b1;                 expect_o("vector_b", O_VECTOR, 16'h0200);
        tick();                                       expect_o("idle_b", O_NONE, 16'h0200);

        // Reset during the second DRAIN cycle.
        tick(); hif.int_req_i = 1'b1; hif.id_epc_i = 16'h0BEE;
                                                      expect_o("int_accept_c", O_BUBBLE, 16'h0200);
        tick(); hif.int_req_i = 1'b1;                 expect_o("drain_1c", O_BUBBLE, 16'h0BEE);
        tick(); hif.int_req_i = 1'b1; rst = 1'b1;     expect_o("reset_in_drain", O_NONE, 16'h0BEE);
        tick();                                       expect_o("run_after_reset", O_NONE, 16'h0000);
        tick();                                       expect_o("no_late_ack", O_NONE, 16'h0000);
        tick(); hif.int_req_i = 1'b1; hif.id_epc_i = 16'h0C00;
                                                      expect_o("reaccept", O_BUBBLE, 16'h0000);
        tick(); hif.int_req_i = 1'b1;                 expect_o("drain_1d", O_BUBBLE, 16'h0C00);
        tick(); hif.int_req_i = 1'b1;                 expect_o("drain_2d", O_BUBBLE, 16'h0C00);
        tick(); hif.int_req_i = 1'b1;                 expect_o("vector_d", O_VECTOR, 16'h0C00);
        tick();                                       expect_o("idle_d", O_NONE, 16'h0C00);

`ifdef HAZARD_PERF_CNT_EN
        // Counter: clear, 5 stall cycles, then saturation.
        tick(); rst = 1'b1;                           expect_o("perf_reset", O_NONE, 16'h0C00);
        for (int i = 0; i < 5; i++) begin
            tick(); hif.mem_if_conflict_i = 1'b1;     expect_o("perf_stall", O_CONFL, 16'h0000);
        end
        tick();                                       expect_o("perf_count_5", O_NONE, 16'h0000);
        for (int i = 0; i < 65540; i++) begin
            tick(); hif.mem_if_conflict_i = 1'b1;
        end
        model_cnt = 16'hFFFF;
        tick();                                       expect_o("perf_saturated", O_NONE, 16'h0000);
        tick(); hif.mem_if_conflict_i = 1'b1;         expect_o("perf_sat_stall", O_CONFL, 16'h0000);
        tick();                                       expect_o("perf_sat_hold", O_NONE, 16'h0000);
`endif

        // Let the monitor drain the scoreboard, within a bounded number of cycles.
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and interrupt-entry controller for the 16-bit five-stage core.
- Generates the stall and flush controls consumed by the PC, IF/ID and ID/EX registers; `flush_id_o` drives the ID/EX `flush_id_i` input.
- Detects load-use and instruction-memory structural hazards, and squashes after taken branches.
- Sequences interrupt entry with a drain FSM that captures EPC.

Parameters:
- NO_REG, 4'hF: regdst encoding meaning "no register write".
- DRAIN_CYCLES, 3: bubble cycles inserted before vectoring (legal 1..15).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- id_regsrc1_i  in  4  source reg 1 of instruction in ID.
- id_regsrc2_i  in  4  source reg 2 of instruction in ID.
- id_rd1_en_i  in  1  ID instruction reads src1.
- id_rd2_en_i  in  1  ID instruction reads src2.
- ex_memread_i  in  1  instruction in EX is a load.
- ex_regdst_i  in  4  destination reg of instruction in EX.
- id_branch_taken_i  in  1  branch/jump in ID resolved taken.
- mem_if_conflict_i  in  1  MEM stage occupies instruction RAM this cycle.
- int_req_i  in  1  level interrupt request, held until acked.
- id_epc_i  in  16  PC of instruction in ID.
- pc_stall_o  out  1  hold PC.
- if_id_stall_o  out  1  hold IF/ID.
- flush_if_o  out  1  load bubble into IF/ID.
- flush_id_o  out  1  load bubble into ID/EX.
- pc_vector_o  out  1  PC selects interrupt vector.
- int_ack_o  out  1  interrupt accepted (one cycle).
- epc_o  out  16  captured exception PC.
- stall_cnt_o  out  16  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset is synchronous.
  - On the first clock edge with RST=1: state=RUN, cnt=0, epc_o=0, stall_cnt_o=0.
  - While RST=1, all 1-bit outputs are forced to 0.
- All control outputs are combinational from state and inputs. Only state, cnt, epc and stall_cnt are registered.
- load_use = ex_memread_i & (ex_regdst_i != NO_REG) & ((id_rd1_en_i & id_regsrc1_i==ex_regdst_i) | (id_rd2_en_i & id_regsrc2_i==ex_regdst_i)).
- State RUN, evaluated in priority order:
  1. Interrupt accept: int_req_i & !load_use & !id_branch_taken_i.
     - Outputs: pc_stall=1, if_id_stall=1, flush_id=1, flush_if=0.
     - epc <= id_epc_i.
     - If DRAIN_CYCLES==1, next state is VECTOR; otherwise next state is DRAIN with cnt <= DRAIN_CYCLES-2.
  2. load_use: pc_stall=1, if_id_stall=1, flush_id=1, flush_if=0. This gives exactly one bubble, because the bubble clears ex_memread next cycle. Also applies when mem_if_conflict_i=1.
  3. id_branch_taken_i: flush_if=1, pc_stall=0. The branch wins over mem_if_conflict_i because the wrong-path fetch is discarded anyway.
  4. mem_if_conflict_i: pc_stall=1, flush_if=1, if_id_stall=0.
  5. Otherwise all outputs are 0.
- State DRAIN:
  - Outputs: pc_stall=1, if_id_stall=1, flush_id=1. All inputs except RST are ignored.
  - If cnt==0, next state is VECTOR; else cnt <= cnt-1.
- State VECTOR (1 cycle):
  - Outputs: pc_vector=1, flush_if=1, int_ack=1; stalls 0.
  - Next state is RUN.
  - int_req_i must drop the cycle after int_ack_o; a still-high request is treated as new.
- Total interrupt-entry latency = DRAIN_CYCLES bubble cycles (accept cycle included), then one VECTOR cycle.
- epc_o holds its value until the next accept. It is not cleared by VECTOR.
- Reset mid-DRAIN or mid-VECTOR:
  - Returns to RUN with epc_o=0.
  - The pending interrupt is not acked.
  - The interrupt is re-accepted after reset if int_req_i is still high.
- Unused state encodings recover to RUN on the next edge.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments by 1 on every edge where pc_stall_o=1, RST=0 and state!=VECTOR.
  - It saturates at 16'hFFFF (no wrap) and resets to 0.
- Undefined: stall_cnt_o tied to 16'h0000 and no counter flops are generated.

Test Plan:
- EX has load to r3 (ex_memread=1, ex_regdst=3); ID reads r3 on src2 (rd2_en=1) -> one cycle of pc_stall=1, if_id_stall=1, flush_id=1; next cycle all 0.
- Same as above but ex_regdst=NO_REG, or rd2_en=0 -> no stall. Same as above with mem_if_conflict=1 -> pc_stall=1, if_id_stall=1, flush_id=1, flush_if=0.
- id_branch_taken=1 with mem_if_conflict=1 -> flush_if=1, pc_stall=0; mem_if_conflict alone -> pc_stall=1, flush_if=1, if_id_stall=0.
- int_req=1, id_epc=16'h0124, no hazards, DRAIN_CYCLES=3 -> 3 cycles of flush_id=1 and pc_stall=1, then 1 cycle of pc_vector=int_ack=flush_if=1, epc_o=16'h0124; int_req held during load_use -> accept delayed 1 cycle.
- RST pulsed during the second DRAIN cycle -> next cycle RUN, all outputs 0, epc_o=0, no int_ack.
- With HAZARD_PERF_CNT_EN defined: 5 stall cycles -> stall_cnt_o=5; counter preloaded near max via a long stall run -> holds at 16'hFFFF. With the macro undefined -> stall_cnt_o stays 0.
